// File: rtl/rv32i_types.sv
// Shared RV32I core types.
// instr_pkt  : result packet carried from functional units to the common data bus.
// CDB_N_FU   : number of functional units feeding the CDB arbiter.
// FU_*       : per-unit result port indices on the arbiter.
package rv32i_types;

    typedef struct packed {
        logic        i_valid;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [3:0]  rob_idx;
    } instr_pkt;

    localparam int unsigned CDB_N_FU = 4;

    localparam int unsigned FU_ALU = 0;
    localparam int unsigned FU_MUL = 1;
    localparam int unsigned FU_DIV = 2;
    localparam int unsigned FU_BR  = 3;

endpackage

// File: rtl/wb_fifo.sv
// Per-unit writeback FIFO with empty-bypass.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush, empties the FIFO (wins over push/pop)
//   push, din  : write a packet
//   pop        : consume the head; when empty, consumes din directly (bypass)
//   dout       : head packet, or din when empty
//   empty      : no stored entries
//   count      : stored entry count
module wb_fifo
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  instr_pkt                     din,
    input  logic                         pop,
    output instr_pkt                     dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    instr_pkt        mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full;
    logic            wr_en;
    logic            rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    assign count = count_q;

    // A push into an empty FIFO that is popped in the same cycle passes straight
    // through without being stored. A push into a full FIFO is kept only when the
    // head leaves in the same cycle; the freed slot is the one being written.
    assign wr_en = push & ~(empty & pop) & (~full | pop);
    assign rd_en = pop & ~empty;

    // Combinational read of the old head; a same-slot write lands at the edge.
    assign dout = empty ? din : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(wr_en) - CntW'(rd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    overflow_check: assert property (
        @(posedge clk) disable iff (!rst_n || clear) !(push && !pop && full)
    ) else $error("wb_fifo overflow: push to full FIFO dropped");

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Buffers one-cycle result pulses from N_FU functional units in per-unit FIFOs
// and round-robin grants them onto a registered CDB packet.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   br_flush   : discard all buffered results and the CDB packet
//   fu_pkt     : per-unit result packets, i_valid is a one-cycle pulse
//   fu_stall   : per-unit back-pressure (FIFO nearly full)
//   cdb_ready  : downstream accepts cdb_pkt this cycle
//   cdb_pkt    : registered CDB broadcast, i_valid marks a valid broadcast
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned N_FU  = CDB_N_FU,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_flush,
    input  instr_pkt        fu_pkt [N_FU],
    output logic [N_FU-1:0] fu_stall,
    input  logic            cdb_ready,
    output instr_pkt        cdb_pkt
);

    localparam int unsigned PtrW = $clog2(N_FU);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned DblW = 2 * N_FU;

    logic [N_FU-1:0] push;
    logic [N_FU-1:0] pop;
    logic [N_FU-1:0] empty;
    logic [N_FU-1:0] req;
    logic [CntW-1:0] count [N_FU];
    instr_pkt        fifo_dout [N_FU];

    instr_pkt        cdb_q, cdb_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] win_idx;
    logic            grant_valid;
    logic            load;
    logic            grant;
    logic [DblW-1:0] req_dbl;
    logic [DblW-1:0] req_masked;

    // Output register may take a new packet when empty or being consumed.
    assign load  = ~cdb_q.i_valid | cdb_ready;
    assign grant = ~br_flush & load & grant_valid;

    for (genvar i = 0; i < N_FU; i++) begin : g_fu
        assign push[i]     = fu_pkt[i].i_valid & ~br_flush;
        // A same-cycle pulse is a candidate too: the FIFO bypasses it.
        assign req[i]      = ~empty[i] | push[i];
        assign pop[i]      = grant & (win_idx == PtrW'(i));
        assign fu_stall[i] = (count[i] >= CntW'(DEPTH - 1));

        wb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (br_flush),
            .push  (push[i]),
            .din   (fu_pkt[i]),
            .pop   (pop[i]),
            .dout  (fifo_dout[i]),
            .empty (empty[i]),
            .count (count[i])
        );
    end

    // Round-robin: duplicate the request vector and mask off the lower copy
    // below ptr; the lowest set bit then wraps naturally into the upper copy.
    always_comb begin
        req_dbl     = {req, req};
        req_masked  = req_dbl & ~((DblW'(1) << ptr_q) - DblW'(1));
        grant_valid = 1'b0;
        win_idx     = '0;
        for (int j = int'(DblW) - 1; j >= 0; j--) begin
            if (req_masked[j]) begin
                grant_valid = 1'b1;
                win_idx     = (j >= int'(N_FU)) ? PtrW'(j - int'(N_FU)) : PtrW'(j);
            end
        end
    end

    always_comb begin
        cdb_d = cdb_q;
        ptr_d = ptr_q;
        if (br_flush) begin
            cdb_d.i_valid = 1'b0;
        end else if (load) begin
            if (grant_valid) begin
                cdb_d         = fifo_dout[win_idx];
                cdb_d.i_valid = 1'b1;
                ptr_d         = (win_idx == PtrW'(N_FU - 1)) ? '0 : win_idx + 1'b1;
            end else begin
                cdb_d.i_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_q <= '0;
            ptr_q <= '0;
        end else begin
            cdb_q <= cdb_d;
            ptr_q <= ptr_d;
        end
    end

    assign cdb_pkt = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N = CDB_N_FU;
    localparam int D = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          br_flush;
    logic          cdb_ready;
    instr_pkt      fu_pkt [N];
    logic [N-1:0]  fu_stall;
    instr_pkt      cdb_pkt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-unit packet queues, the CDB register, RR pointer.
    instr_pkt mq [N][$];
    instr_pkt m_cdb;
    int       m_ptr;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .N_FU  (N),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .br_flush  (br_flush),
        .fu_pkt    (fu_pkt),
        .fu_stall  (fu_stall),
        .cdb_ready (cdb_ready),
        .cdb_pkt   (cdb_pkt)
    );

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_cdb = '0;
        m_ptr = 0;
    endtask

    // One clock of the behavioural rules, using the inputs currently driven.
    task automatic model_step();
        bit cand [N];
        int win;
        bit take;
        win  = -1;
        take = !m_cdb.i_valid || cdb_ready;
        if (br_flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_cdb.i_valid = 1'b0;
            return;
        end
        for (int i = 0; i < N; i++) cand[i] = (mq[i].size() > 0) || fu_pkt[i].i_valid;
        if (take) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (win < 0 && cand[idx]) win = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (fu_pkt[i].i_valid && (mq[i].size() < D || i == win)) mq[i].push_back(fu_pkt[i]);
        end
        if (take) begin
            if (win >= 0) begin
                m_cdb         = mq[win].pop_front();
                m_cdb.i_valid = 1'b1;
                m_ptr         = (win + 1) % N;
            end else begin
                m_cdb.i_valid = 1'b0;
            end
        end
    endtask

    function automatic logic [N-1:0] model_stall();
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) s[i] = (mq[i].size() >= D - 1);
        return s;
    endfunction

    task automatic check_state(string tag);
        logic [N-1:0] exp_stall;
        exp_stall = model_stall();
        n_cmp++;
        assert (cdb_pkt === m_cdb) else begin
            n_bad++;
            $error("FAIL %s cdb_pkt observed=%h expected=%h", tag, cdb_pkt, m_cdb);
        end
        n_cmp++;
        assert (fu_stall === exp_stall) else begin
            n_bad++;
            $error("FAIL %s fu_stall observed=%b expected=%b", tag, fu_stall, exp_stall);
        end
    endtask

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) fu_pkt[i] = '0;
        br_flush = 1'b0;
    endtask

    task automatic pulse(int unit, logic [31:0] data);
        instr_pkt p;
        p.i_valid = 1'b1;
        p.pc      = $urandom();
        p.rd_addr = 5'($urandom());
        p.rd_data = data;
        p.rob_idx = 4'($urandom());
        fu_pkt[unit] = p;
    endtask

    // Advance one clock, sample 1 time unit after the edge, then drop pulses.
    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_state(tag);
        idle_inputs();
    endtask

    initial begin
        rst_n     = 1'b0;
        cdb_ready = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check_state("reset");
        #11;
        rst_n = 1'b1;
        tick("post_reset");

        // Simultaneous burst from all units, twice.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) pulse(i, 32'h100 + 32'(i));
            for (int i = 0; i < N; i++) begin
                tick("burst");
                check_val("burst_order", cdb_pkt.rd_data, 32'h100 + 32'(i));
            end
            tick("burst_drain");
            check_val("burst_idle", 32'(cdb_pkt.i_valid), 32'h0);
        end

        // Single divide result: one-cycle latency, then idle.
        pulse(FU_DIV, 32'h0000_0007);
        tick("single");
        check_val("single_valid", 32'(cdb_pkt.i_valid), 32'h1);
        check_val("single_data", cdb_pkt.rd_data, 32'h7);
        tick("single_idle");
        check_val("single_idle_valid", 32'(cdb_pkt.i_valid), 32'h0);

        // Downstream stalled while div sends two results.
        cdb_ready = 1'b0;
        pulse(FU_DIV, 32'hd1);
        tick("hold_1");
        pulse(FU_DIV, 32'hd2);
        tick("hold_2");
        check_val("hold_stall_div", 32'(fu_stall[FU_DIV]), 32'h1);
        for (int c = 0; c < 3; c++) begin
            tick("hold_wait");
            check_val("hold_stable", cdb_pkt.rd_data, 32'hd1);
        end
        cdb_ready = 1'b1;
        tick("hold_release");
        check_val("hold_second", cdb_pkt.rd_data, 32'hd2);
        tick("hold_drain");

        // Full FIFO with same-cycle push and pop.
        cdb_ready = 1'b0;
        pulse(FU_DIV, 32'ha0);
        tick("full_a");
        pulse(FU_DIV, 32'ha1);
        tick("full_b");
        pulse(FU_DIV, 32'ha2);
        tick("full_c");
        check_val("full_count_stall", 32'(fu_stall[FU_DIV]), 32'h1);
        cdb_ready = 1'b1;
        pulse(FU_DIV, 32'ha3);
        tick("full_pushpop");
        check_val("full_oldest", cdb_pkt.rd_data, 32'ha1);
        for (int c = 0; c < 4; c++) tick("full_drain");
        check_val("full_drained", 32'(cdb_pkt.i_valid), 32'h0);

        // Flush with buffered results and a same-cycle push.
        cdb_ready = 1'b0;
        pulse(FU_ALU, 32'hf0);
        tick("flush_fill0");
        pulse(FU_MUL, 32'hf1);
        pulse(FU_DIV, 32'hf2);
        pulse(FU_BR,  32'hf3);
        tick("flush_fill1");
        pulse(FU_ALU, 32'hf4);
        br_flush = 1'b1;
        cdb_ready = 1'b1;
        tick("flush");
        check_val("flush_valid", 32'(cdb_pkt.i_valid), 32'h0);
        check_val("flush_stall", 32'(fu_stall), 32'h0);
        for (int c = 0; c < 3; c++) tick("flush_after");

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < N; i++) pulse(i, 32'h200 + 32'(i));
        tick("areset_burst0");
        tick("areset_burst1");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("areset_valid", 32'(cdb_pkt.i_valid), 32'h0);
        check_val("areset_stall", 32'(fu_stall), 32'h0);
        #2;
        rst_n = 1'b1;
        pulse(FU_BR, 32'h300);
        pulse(FU_ALU, 32'h301);
        tick("areset_new");
        check_val("areset_fu0_first", cdb_pkt.rd_data, 32'h301);
        tick("areset_next");
        check_val("areset_fu3_next", cdb_pkt.rd_data, 32'h300);
        tick("areset_drain");

        // Randomized traffic with legal occupancy (never more pushes than space).
        for (int c = 0; c < 400; c++) begin
            cdb_ready = ($urandom_range(0, 3) != 0);
            br_flush  = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                if (mq[i].size() < D && $urandom_range(0, 2) == 0) pulse(i, $urandom());
            end
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
